// File: rtl/dsi_seq_pkg.sv
// ---------------------------------------------------------------------------
// dsi_seq_pkg
// Shared definitions for the DSI line sequencer: DSI data-type codes, the
// sequencer state enumeration and the RGB888 word-count helper.
// Optional build macro: DSI_SEQ_SYNC_END_EN (sync-pulse mode, adds the VSE/HSE
// codes and states).
// ---------------------------------------------------------------------------
package dsi_seq_pkg;

    localparam logic [5:0] DT_VSS    = 6'h01;
    localparam logic [5:0] DT_HSS    = 6'h21;
    localparam logic [5:0] DT_RGB888 = 6'h3E;
`ifdef DSI_SEQ_SYNC_END_EN
    localparam logic [5:0] DT_VSE    = 6'h11;
    localparam logic [5:0] DT_HSE    = 6'h31;
`endif

    typedef enum logic [3:0] {
        IDLE,
        VSS,
        HSS,
        FILL,
        WAIT_DONE,
        LINE_PKT,
        NEXT_LINE,
        FRAME_END
`ifdef DSI_SEQ_SYNC_END_EN
        , VSE
        , HSE
`endif
    } seq_state_e;

    // RGB888 long-packet payload size in bytes, truncated to the 16-bit WC field
    function automatic logic [15:0] wc_rgb888(input logic [31:0] h);
        logic [31:0] prod;
        prod = h * 32'd3;
        return prod[15:0];
    endfunction

endpackage

// File: rtl/dsi_pkt_req_reg.sv
// ---------------------------------------------------------------------------
// dsi_pkt_req_reg
// Packet request register shared by every packet-issuing sequencer state.
// A load pulse captures type/WC and raises pkt_req; the request (with its type
// and WC) is held stable until the packet builder acknowledges it.
// Ports:
//   pclk, rst            clock, synchronous active-high reset
//   load                 one-cycle pulse: issue a new request
//   load_type, load_wc   data type / word count for the new request
//   pkt_ack              builder accepted the pending request
//   pkt_req              request pending
//   pkt_type, pkt_wc     registered request contents
// ---------------------------------------------------------------------------
module dsi_pkt_req_reg (
    input  logic        pclk,
    input  logic        rst,
    input  logic        load,
    input  logic [5:0]  load_type,
    input  logic [15:0] load_wc,
    input  logic        pkt_ack,
    output logic        pkt_req,
    output logic [5:0]  pkt_type,
    output logic [15:0] pkt_wc
);

    always_ff @(posedge pclk) begin
        if (rst) begin
            pkt_req  <= 1'b0;
            pkt_type <= '0;
            pkt_wc   <= '0;
        end else if (load) begin
            pkt_req  <= 1'b1;
            pkt_type <= load_type;
            pkt_wc   <= load_wc;
        end else if (pkt_req && pkt_ack) begin
            pkt_req  <= 1'b0;
        end
    end

endmodule

// File: rtl/dsi_line_sequencer.sv
// ---------------------------------------------------------------------------
// dsi_line_sequencer
// Frame/line controller for the DSI transmit path. Walks the vertical timing
// (VBP, active, VFP lines), issues VSS/HSS short-packet requests, gates one
// burst of source pixels per active line into the line FIFO, waits for the
// FIFO completion pulse and then requests the RGB888 long packet.
// Optional build macro: DSI_SEQ_SYNC_END_EN -- sync-pulse mode, VSS is followed
// by VSE and every HSS by HSE.
// Ports:
//   pclk, rst                        clock, synchronous active-high reset
//   frame_start                      start request (honoured only when idle)
//   h_active, v_active, vbp, vfp     frame geometry, latched at frame start
//   src_valid, src_pixel, src_ready  pixel source handshake
//   fifo_data_valid, fifo_pixel      pixel stream into the line FIFO
//   fifo_wc                          line byte count for the FIFO
//   fifo_done                        FIFO line-complete pulse
//   pkt_req, pkt_type, pkt_wc        packet request to the packet builder
//   pkt_ack                          packet builder accepted the request
//   busy                             sequencer not idle
//   frame_done                       one-cycle pulse at frame end
//   underrun_err                     sticky source underrun flag
// ---------------------------------------------------------------------------
module dsi_line_sequencer
    import dsi_seq_pkg::*;
#(
    parameter int H_W = 16,
    parameter int V_W = 12
) (
    input  logic           pclk,
    input  logic           rst,
    input  logic           frame_start,
    input  logic [H_W-1:0] h_active,
    input  logic [V_W-1:0] v_active,
    input  logic [V_W-1:0] vbp,
    input  logic [V_W-1:0] vfp,
    input  logic           src_valid,
    input  logic [23:0]    src_pixel,
    output logic           src_ready,
    output logic           fifo_data_valid,
    output logic [23:0]    fifo_pixel,
    output logic [15:0]    fifo_wc,
    input  logic           fifo_done,
    output logic           pkt_req,
    output logic [5:0]     pkt_type,
    output logic [15:0]    pkt_wc,
    input  logic           pkt_ack,
    output logic           busy,
    output logic           frame_done,
    output logic           underrun_err
);

    // Line arithmetic carries two extra bits so vbp+v_active+vfp cannot wrap
    localparam int LW = V_W + 2;

    seq_state_e     state, state_n;
    logic [H_W-1:0] h_act_q, cnt;
    logic [LW-1:0]  vbp_q, vact_q, total_q, line_q;

    logic        ack_ok, accept, last_pixel, underrun, line_active, last_line;
    logic        pkt_load;
    logic [5:0]  pkt_load_type;
    logic [15:0] pkt_load_wc;

    assign ack_ok      = pkt_req & pkt_ack;
    assign src_ready   = (state == FILL) && (cnt < h_act_q);
    assign accept      = src_valid & src_ready;
    assign last_pixel  = (cnt == h_act_q - H_W'(1));
    // Underrun only once the line has started; before the first pixel FILL waits
    assign underrun    = (state == FILL) && (cnt != '0) && !src_valid;
    assign line_active = (line_q >= vbp_q) && (line_q < vbp_q + vact_q) && (h_act_q != '0);
    assign last_line   = (line_q == total_q - LW'(1));
    assign busy        = (state != IDLE);
    assign frame_done  = (state == FRAME_END);

    always_ff @(posedge pclk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n       = state;
        pkt_load      = 1'b0;
        pkt_load_type = '0;
        pkt_load_wc   = '0;

        case (state)
            IDLE:      if (frame_start) state_n = VSS;
`ifdef DSI_SEQ_SYNC_END_EN
            VSS:       if (ack_ok) state_n = VSE;
            VSE:       if (ack_ok) state_n = (total_q == '0) ? FRAME_END : HSS;
            HSS:       if (ack_ok) state_n = HSE;
            HSE:       if (ack_ok) state_n = line_active ? FILL : NEXT_LINE;
`else
            VSS:       if (ack_ok) state_n = (total_q == '0) ? FRAME_END : HSS;
            HSS:       if (ack_ok) state_n = line_active ? FILL : NEXT_LINE;
`endif
            FILL:      if ((accept && last_pixel) || underrun) state_n = WAIT_DONE;
            WAIT_DONE: if (fifo_done) state_n = LINE_PKT;
            LINE_PKT:  if (ack_ok) state_n = NEXT_LINE;
            NEXT_LINE: state_n = last_line ? FRAME_END : HSS;
            FRAME_END: state_n = IDLE;
            default:   state_n = IDLE;
        endcase

        // A request is issued on entry to each packet state; the request
        // register holds it there until acknowledged.
        if (state_n != state) begin
            case (state_n)
                VSS: begin
                    pkt_load      = 1'b1;
                    pkt_load_type = DT_VSS;
                end
                HSS: begin
                    pkt_load      = 1'b1;
                    pkt_load_type = DT_HSS;
                end
`ifdef DSI_SEQ_SYNC_END_EN
                VSE: begin
                    pkt_load      = 1'b1;
                    pkt_load_type = DT_VSE;
                end
                HSE: begin
                    pkt_load      = 1'b1;
                    pkt_load_type = DT_HSE;
                end
`endif
                LINE_PKT: begin
                    pkt_load      = 1'b1;
                    pkt_load_type = DT_RGB888;
                    pkt_load_wc   = wc_rgb888(32'(cnt));
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            h_act_q         <= '0;
            vbp_q           <= '0;
            vact_q          <= '0;
            total_q         <= '0;
            line_q          <= '0;
            cnt             <= '0;
            fifo_wc         <= '0;
            fifo_data_valid <= 1'b0;
            fifo_pixel      <= '0;
            underrun_err    <= 1'b0;
        end else begin
            fifo_data_valid <= accept;
            if (accept) fifo_pixel <= src_pixel;

            if (state == IDLE && frame_start) begin
                h_act_q      <= h_active;
                vbp_q        <= LW'(vbp);
                vact_q       <= LW'(v_active);
                total_q      <= LW'(vbp) + LW'(v_active) + LW'(vfp);
                fifo_wc      <= wc_rgb888(32'(h_active));
                underrun_err <= 1'b0;
                line_q       <= '0;
                cnt          <= '0;
            end

            if (accept)   cnt <= cnt + H_W'(1);
            if (underrun) underrun_err <= 1'b1;

            if (state == NEXT_LINE) begin
                cnt    <= '0;
                line_q <= line_q + LW'(1);
            end
        end
    end

    dsi_pkt_req_reg u_pkt_req (
        .pclk      (pclk),
        .rst       (rst),
        .load      (pkt_load),
        .load_type (pkt_load_type),
        .load_wc   (pkt_load_wc),
        .pkt_ack   (pkt_ack),
        .pkt_req   (pkt_req),
        .pkt_type  (pkt_type),
        .pkt_wc    (pkt_wc)
    );

endmodule

// File: tb/tb_dsi_line_sequencer.sv
module tb_dsi_line_sequencer;

    logic        pclk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [15:0] h_active;
    logic [11:0] v_active, vbp, vfp;
    logic        src_valid;
    logic [23:0] src_pixel;
    logic        src_ready;
    logic        fifo_data_valid;
    logic [23:0] fifo_pixel;
    logic [15:0] fifo_wc;
    logic        fifo_done;
    logic        pkt_req;
    logic [5:0]  pkt_type;
    logic [15:0] pkt_wc;
    logic        pkt_ack;
    logic        busy;
    logic        frame_done;
    logic        underrun_err;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    dsi_line_sequencer #(.H_W(16), .V_W(12)) dut (
        .pclk            (pclk),
        .rst             (rst),
        .frame_start     (frame_start),
        .h_active        (h_active),
        .v_active        (v_active),
        .vbp             (vbp),
        .vfp             (vfp),
        .src_valid       (src_valid),
        .src_pixel       (src_pixel),
        .src_ready       (src_ready),
        .fifo_data_valid (fifo_data_valid),
        .fifo_pixel      (fifo_pixel),
        .fifo_wc         (fifo_wc),
        .fifo_done       (fifo_done),
        .pkt_req         (pkt_req),
        .pkt_type        (pkt_type),
        .pkt_wc          (pkt_wc),
        .pkt_ack         (pkt_ack),
        .busy            (busy),
        .frame_done      (frame_done),
        .underrun_err    (underrun_err)
    );

    // Passive monitors: accepted packets, FIFO beats and frame_done cycles
    logic [5:0]  log_t [0:63];
    logic [15:0] log_w [0:63];
    int pkt_n  = 0;
    int dv_cnt = 0;
    int fd_cnt = 0;

    always @(posedge pclk) begin
        if (!rst && pkt_req && pkt_ack && pkt_n < 64) begin
            log_t[pkt_n] <= pkt_type;
            log_w[pkt_n] <= pkt_wc;
            pkt_n        <= pkt_n + 1;
        end
        if (fifo_data_valid) dv_cnt <= dv_cnt + 1;
        if (frame_done)      fd_cnt <= fd_cnt + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int h, input int va, input int b, input int f);
        h_active = 16'(h);
        v_active = 12'(va);
        vbp      = 12'(b);
        vfp      = 12'(f);
    endtask

    task automatic check_seq(input string name, input int base,
                             input logic [5:0] et[$], input logic [15:0] ew[$]);
        chk({name, "_pkt_count"}, pkt_n - base, et.size());
        for (int i = 0; i < et.size(); i++) begin
            chk($sformatf("%s_type%0d", name, i), log_t[base + i], et[i]);
            if (et[i] == 6'h3E)
                chk($sformatf("%s_wc%0d", name, i), log_w[base + i], ew[i]);
        end
    endtask

    // Runs one frame: pulses frame_start, keeps the source valid (optionally
    // dropping it after drop_after pixels of a line), answers each line burst
    // with fifo_done, optionally re-pulses frame_start, stops after frame_done.
    task automatic run_frame(input int drop_after, input int restart_at, output logic fd_busy);
        int   acc     = 0;
        int   cyc     = 0;
        logic prev_dv = 1'b0;
        logic seen_fd = 1'b0;
        fd_busy     = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        while (!seen_fd && cyc < 400) begin
            fifo_done = 1'b0;
            if (prev_dv && !fifo_data_valid) begin
                fifo_done = 1'b1;
                acc = 0;
            end
            src_valid = (drop_after == 0) || (acc < drop_after);
            if (src_valid && src_ready) acc++;
            frame_start = (cyc == restart_at);
            if (frame_done) begin
                seen_fd = 1'b1;
                fd_busy = busy;
            end
            prev_dv = fifo_data_valid;
            tick();
            cyc++;
        end
        frame_start = 1'b0;
        fifo_done   = 1'b0;
        src_valid   = 1'b1;
        chk("frame_completes", seen_fd, 1);
    endtask

    initial begin
        logic [5:0]  et[$];
        logic [15:0] ew[$];
        logic        fdb;
        int          base, dv0, fd0, n_extra;

        rst = 1'b1; frame_start = 1'b0; src_valid = 1'b0; src_pixel = 24'h123456;
        fifo_done = 1'b0; pkt_ack = 1'b0;
        set_cfg(0, 0, 0, 0);
        repeat (3) tick();

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_pkt_req", pkt_req, 0);
        chk("rst_pkt_type", pkt_type, 0);
        chk("rst_pkt_wc", pkt_wc, 0);
        chk("rst_fifo_dv", fifo_data_valid, 0);
        chk("rst_fifo_pixel", fifo_pixel, 0);
        chk("rst_fifo_wc", fifo_wc, 0);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_underrun", underrun_err, 0);
        rst = 1'b0;
        tick();

        // Full frame: vbp=1, v_active=2, vfp=1, h_active=4, immediate ack
        pkt_ack = 1'b1;
        set_cfg(4, 2, 1, 1);
        base = pkt_n; dv0 = dv_cnt; fd0 = fd_cnt;
        run_frame(0, -1, fdb);
`ifdef DSI_SEQ_SYNC_END_EN
        et = '{6'h01, 6'h11, 6'h21, 6'h31, 6'h21, 6'h31, 6'h3E, 6'h21, 6'h31, 6'h3E, 6'h21, 6'h31};
        ew = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd12, 16'd0, 16'd0, 16'd12, 16'd0, 16'd0};
`else
        et = '{6'h01, 6'h21, 6'h21, 6'h3E, 6'h21, 6'h3E, 6'h21};
        ew = '{16'd0, 16'd0, 16'd0, 16'd12, 16'd0, 16'd12, 16'd0};
`endif
        check_seq("frame1", base, et, ew);
        chk("frame1_dv_beats", dv_cnt - dv0, 8);
        chk("frame1_fd_count", fd_cnt - fd0, 1);
        chk("frame1_busy_with_fd", fdb, 1);
        chk("frame1_busy_after", busy, 0);
        chk("frame1_fd_after", frame_done, 0);
        chk("frame1_fifo_wc", fifo_wc, 12);
        chk("frame1_no_underrun", underrun_err, 0);

        // Underrun: source drops after 2 of 4 pixels
        set_cfg(4, 1, 0, 0);
        base = pkt_n; dv0 = dv_cnt;
        run_frame(2, -1, fdb);
`ifdef DSI_SEQ_SYNC_END_EN
        et = '{6'h01, 6'h11, 6'h21, 6'h31, 6'h3E};
        ew = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd6};
`else
        et = '{6'h01, 6'h21, 6'h3E};
        ew = '{16'd0, 16'd0, 16'd6};
`endif
        check_seq("underrun", base, et, ew);
        chk("underrun_flag", underrun_err, 1);
        chk("underrun_dv_beats", dv_cnt - dv0, 2);

        // Delayed ack on HSS: one porch line only
        pkt_ack = 1'b0;
        set_cfg(4, 0, 1, 0);
        base = pkt_n;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("underrun_cleared", underrun_err, 0);
        chk("vss_req", pkt_req, 1);
        chk("vss_type", pkt_type, 6'h01);
        pkt_ack = 1'b1;
        tick();
        pkt_ack = 1'b0;
`ifdef DSI_SEQ_SYNC_END_EN
        chk("vse_type", pkt_type, 6'h11);
        pkt_ack = 1'b1;
        tick();
        pkt_ack = 1'b0;
`endif
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("hss_req_held%0d", i), pkt_req, 1);
            chk($sformatf("hss_type_held%0d", i), pkt_type, 6'h21);
            chk($sformatf("hss_no_fd%0d", i), frame_done, 0);
            if (i == 5) pkt_ack = 1'b1;
            tick();
        end
        pkt_ack = 1'b0;
`ifdef DSI_SEQ_SYNC_END_EN
        chk("hse_type", pkt_type, 6'h31);
        pkt_ack = 1'b1;
        tick();
        pkt_ack = 1'b0;
`endif
        chk("hss_req_drop", pkt_req, 0);
        chk("delay_fd_not_yet", frame_done, 0);
        tick();
        chk("delay_fd_pulse", frame_done, 1);
        tick();
        chk("delay_busy_after", busy, 0);
`ifdef DSI_SEQ_SYNC_END_EN
        chk("delay_pkt_count", pkt_n - base, 4);
`else
        chk("delay_pkt_count", pkt_n - base, 2);
`endif

        // frame_start re-pulsed mid-frame must be ignored
        pkt_ack = 1'b1;
        set_cfg(4, 2, 1, 1);
        base = pkt_n; fd0 = fd_cnt;
        run_frame(0, 5, fdb);
`ifdef DSI_SEQ_SYNC_END_EN
        chk("restart_pkt_count", pkt_n - base, 12);
`else
        chk("restart_pkt_count", pkt_n - base, 7);
`endif
        chk("restart_fd_count", fd_cnt - fd0, 1);
        repeat (3) tick();
        chk("restart_stays_idle", busy, 0);

        // Reset during FILL, then a stray fifo_done
`ifdef DSI_SEQ_SYNC_END_EN
        n_extra = 4;
`else
        n_extra = 2;
`endif
        set_cfg(4, 1, 0, 0);
        src_valid = 1'b0;
        base = pkt_n;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (n_extra) tick();
        chk("fill_src_ready", src_ready, 1);
        chk("fill_busy", busy, 1);
        src_pixel = 24'hA5C3E1;
        src_valid = 1'b1;
        tick();
        tick();
        chk("fill_dv", fifo_data_valid, 1);
        chk("fill_pixel", fifo_pixel, 24'hA5C3E1);
        src_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_dv", fifo_data_valid, 0);
        chk("midrst_pixel", fifo_pixel, 0);
        chk("midrst_src_ready", src_ready, 0);
        chk("midrst_pkt_req", pkt_req, 0);
        chk("midrst_fifo_wc", fifo_wc, 0);
        chk("midrst_frame_done", frame_done, 0);
        rst = 1'b0;
        fifo_done = 1'b1;
        tick();
        fifo_done = 1'b0;
        repeat (3) tick();
        chk("late_done_pkt_count", pkt_n - base, n_extra);
        chk("late_done_no_req", pkt_req, 0);
        chk("late_done_idle", busy, 0);

        // Empty frame: total lines == 0
        set_cfg(0, 0, 0, 0);
        base = pkt_n; fd0 = fd_cnt;
        run_frame(0, -1, fdb);
`ifdef DSI_SEQ_SYNC_END_EN
        et = '{6'h01, 6'h11};
        ew = '{16'd0, 16'd0};
`else
        et = '{6'h01};
        ew = '{16'd0};
`endif
        check_seq("empty", base, et, ew);
        chk("empty_fd_count", fd_cnt - fd0, 1);

        // Single one-pixel line
        set_cfg(1, 1, 0, 0);
        base = pkt_n; dv0 = dv_cnt;
        run_frame(0, -1, fdb);
`ifdef DSI_SEQ_SYNC_END_EN
        et = '{6'h01, 6'h11, 6'h21, 6'h31, 6'h3E};
        ew = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd3};
`else
        et = '{6'h01, 6'h21, 6'h3E};
        ew = '{16'd0, 16'd0, 16'd3};
`endif
        check_seq("one_px", base, et, ew);
        chk("one_px_dv_beats", dv_cnt - dv0, 1);
        chk("one_px_fifo_wc", fifo_wc, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
